// File: rtl/store_tid_tracker.sv
// Store transaction-ID allocator and in-flight tracker with fence drain.
// Optional watchdog enabled by defining STORE_TRACKER_TIMEOUT_EN.
module store_tid_tracker #(
  parameter int MAX_OUTSTANDING = 7,
  parameter int TID_WIDTH       = 3,
  parameter int TIMEOUT_CYCLES  = 1024,
  localparam int NUM_TIDS       = 2**TID_WIDTH,
  localparam int CW             = $clog2(MAX_OUTSTANDING+1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 st_req_i,
  output logic                 st_gnt_o,
  output logic [TID_WIDTH-1:0] st_tid_o,
  input  logic                 ack_valid_i,
  input  logic [TID_WIDTH-1:0] ack_tid_i,
  input  logic                 ack_err_i,
  input  logic                 fence_req_i,
  output logic                 fence_done_o,
  output logic [CW-1:0]        outstanding_cnt_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic                 spurious_o,
  output logic                 bus_err_o,
  output logic                 timeout_o
);

  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > NUM_TIDS || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("store_tid_tracker: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_e;

  state_e                state_q, state_d;
  logic [NUM_TIDS-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]         cnt_q;
  logic                  free_any;
  logic [TID_WIDTH-1:0]  free_idx;
  logic                  gnt, valid_ack, bad_ack;

  // Lowest free ID from the registered bitmap, so a just-freed ID is only reusable next cycle.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NUM_TIDS-1; i >= 0; i--) begin
      if (!inflight_q[i]) begin
        free_any = 1'b1;
        free_idx = TID_WIDTH'(i);
      end
    end
  end

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == CW'(MAX_OUTSTANDING));
  assign gnt       = st_req_i & ~full_o & free_any & (state_q == IDLE) & ~fence_req_i;
  assign st_gnt_o  = gnt;
  assign st_tid_o  = gnt ? free_idx : '0;
  assign valid_ack = ack_valid_i &  inflight_q[ack_tid_i];
  assign bad_ack   = ack_valid_i & ~inflight_q[ack_tid_i];
  assign outstanding_cnt_o = cnt_q;

  always_comb begin
    inflight_d = inflight_q;
    if (gnt)       inflight_d[free_idx]  = 1'b1;
    if (valid_ack) inflight_d[ack_tid_i] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= '0;
      cnt_q      <= '0;
      spurious_o <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      cnt_q      <= cnt_q + CW'(gnt) - CW'(valid_ack);
      if (bad_ack)               spurious_o <= 1'b1;
      if (valid_ack & ack_err_i) bus_err_o  <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    fence_done_o = 1'b0;
    case (state_q)
      IDLE:    if (fence_req_i) state_d = DRAIN;
      DRAIN:   if (cnt_q == '0) state_d = DONE;
      DONE: begin
        fence_done_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef STORE_TRACKER_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES+1);
  logic [WW-1:0] wdog_q, wdog_d;

  // Counts cycles without forward progress while stores are pending; saturates at the threshold.
  always_comb begin
    if (empty_o || valid_ack)              wdog_d = '0;
    else if (wdog_q == WW'(TIMEOUT_CYCLES)) wdog_d = wdog_q;
    else                                    wdog_d = wdog_q + WW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q    <= '0;
      timeout_o <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      if (wdog_d == WW'(TIMEOUT_CYCLES)) timeout_o <= 1'b1;
    end
  end
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_store_tid_tracker.sv
// Directed plus randomized bench for store_tid_tracker against a set-of-IDs reference model.
module tb_store_tid_tracker;
  localparam int MAXO = 7;
  localparam int TW   = 3;
  localparam int NT   = 8;
  localparam int TO   = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          st_req_i = 1'b0, ack_valid_i = 1'b0, ack_err_i = 1'b0, fence_req_i = 1'b0;
  logic [TW-1:0] ack_tid_i = '0;
  logic          st_gnt_o, fence_done_o, empty_o, full_o, spurious_o, bus_err_o, timeout_o;
  logic [TW-1:0] st_tid_o;
  logic [2:0]    outstanding_cnt_o;

  store_tid_tracker #(.MAX_OUTSTANDING(MAXO), .TID_WIDTH(TW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .st_req_i(st_req_i), .st_gnt_o(st_gnt_o), .st_tid_o(st_tid_o),
    .ack_valid_i(ack_valid_i), .ack_tid_i(ack_tid_i), .ack_err_i(ack_err_i),
    .fence_req_i(fence_req_i), .fence_done_o(fence_done_o),
    .outstanding_cnt_o(outstanding_cnt_o), .empty_o(empty_o), .full_o(full_o),
    .spurious_o(spurious_o), .bus_err_o(bus_err_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_assert = 0, n_fail = 0, cyc_no = 0, last_done = -1, done_pulses = 0, gnt_seen = 0;
  bit m_inf[NT];
  bit m_drain, m_done, m_spur, m_berr, m_to;
  int m_wd;
  logic          o_gnt;
  logic [TW-1:0] o_tid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < NT; i++) c += int'(m_inf[i]);
    return c;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NT; i++) m_inf[i] = 1'b0;
    m_drain = 0; m_done = 0; m_spur = 0; m_berr = 0; m_to = 0; m_wd = 0;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    st_req_i = 0; ack_valid_i = 0; ack_err_i = 0; fence_req_i = 0; ack_tid_i = '0;
    rst_ni = 1'b0;
    m_clear();
    #1;
    chk("rst_gnt", st_gnt_o, 0);       chk("rst_tid", st_tid_o, 0);
    chk("rst_cnt", outstanding_cnt_o, 0);
    chk("rst_empty", empty_o, 1);      chk("rst_full", full_o, 0);
    chk("rst_done", fence_done_o, 0);  chk("rst_spur", spurious_o, 0);
    chk("rst_berr", bus_err_o, 0);     chk("rst_to", timeout_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  // One clock cycle: drive, compare against model, then advance the model at the edge.
  task automatic cyc(input bit req, input bit av, input int at, input bit ae, input bit fe);
    int c, lz;
    bit busy, eg, valid;
    st_req_i = req; ack_valid_i = av; ack_tid_i = TW'(at); ack_err_i = ae; fence_req_i = fe;
    #3;
    c = m_cnt();
    busy = m_drain || m_done;
    lz = -1;
    for (int i = NT-1; i >= 0; i--) if (!m_inf[i]) lz = i;
    eg = req && (c < MAXO) && (lz >= 0) && !busy && !fe;
    chk("gnt", st_gnt_o, eg);
    chk("tid", st_tid_o, eg ? lz : 0);
    chk("cnt", outstanding_cnt_o, c);
    chk("empty", empty_o, c == 0);
    chk("full", full_o, c == MAXO);
    chk("fence_done", fence_done_o, m_done);
    chk("spurious", spurious_o, m_spur);
    chk("bus_err", bus_err_o, m_berr);
    chk("timeout", timeout_o, m_to);
    o_gnt = st_gnt_o; o_tid = st_tid_o;
    if (fence_done_o === 1'b1) begin last_done = cyc_no; done_pulses++; end
    if (st_gnt_o === 1'b1) gnt_seen++;
    @(posedge clk_i);
    valid = av && m_inf[at];
    if (av && !m_inf[at]) m_spur = 1;
    if (valid && ae) m_berr = 1;
    if (eg) m_inf[lz] = 1;
    if (valid) m_inf[at] = 0;
    if (m_done) m_done = 0;
    else if (m_drain) begin
      if (c == 0) begin m_drain = 0; m_done = 1; end
    end else if (fe) m_drain = 1;
`ifdef STORE_TRACKER_TIMEOUT_EN
    if (c == 0 || valid) m_wd = 0;
    else if (m_wd < TO) m_wd++;
    if (m_wd >= TO) m_to = 1;
`endif
    #1;
    cyc_no++;
  endtask

  initial begin
    int t;
    do_reset();

    // Fill: tids 0..6 granted back-to-back, then blocked by the outstanding limit.
    for (int i = 0; i < MAXO; i++) begin
      cyc(1, 0, 0, 0, 0);
      chk("fill_tid", o_tid, i);
    end
    cyc(1, 0, 0, 0, 0);
    chk("full_no_gnt", o_gnt, 0);
    chk("full_cnt", outstanding_cnt_o, 7);

    // Freed ID is not reusable in the ack cycle, only the next one.
    cyc(1, 1, 3, 0, 0);
    chk("ack_cycle_gnt", o_gnt, 0);
    cyc(1, 0, 0, 0, 0);
    chk("regrant_tid3", o_tid, 3);

    // Same-cycle grant and ack.
    do_reset();
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("same_cyc_tid", o_tid, 1);
    cyc(1, 0, 0, 0, 0);
    chk("same_cyc_cnt", outstanding_cnt_o, 2);

    // Fence with tids 0,1 in flight.
    t = cyc_no; gnt_seen = 0; done_pulses = 0;
    for (int k = 0; k <= 7; k++)
      cyc(1, (k == 3) || (k == 5), (k == 3) ? 1 : 0, 0, k == 0);
    chk("fence_no_gnt", gnt_seen, 0);
    chk("fence_done_at", last_done, t + 7);
    chk("fence_pulses", done_pulses, 1);
    cyc(1, 0, 0, 0, 0);
    chk("fence_resume", o_gnt, 1);

    // Fence on an empty tracker.
    cyc(0, 1, 0, 0, 0);
    t = cyc_no;
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, k == 0);
    chk("fence_empty_at", last_done, t + 2);

    // Error paths.
    cyc(0, 1, 5, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("spurious_set", spurious_o, 1);
    chk("spurious_cnt", outstanding_cnt_o, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("bus_err_set", bus_err_o, 1);
    chk("bus_err_freed", empty_o, 1);

    // Reset in the middle of a drain.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    do_reset();
    cyc(0, 0, 0, 0, 0);

`ifdef STORE_TRACKER_TIMEOUT_EN
    cyc(1, 0, 0, 0, 0);
    repeat (15) cyc(0, 0, 0, 0, 0);
    chk("to_not_yet", timeout_o, 0);
    cyc(0, 0, 0, 0, 0);
    chk("to_set", timeout_o, 1);
    do_reset();
    cyc(1, 0, 0, 0, 0);
    repeat (9) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    repeat (20) cyc(0, 0, 0, 0, 0);
    chk("to_prevented", timeout_o, 0);
`endif

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, int'($urandom_range(0, NT-1)),
          $urandom_range(0, 15) == 0, $urandom_range(0, 40) == 0);
      if ($urandom_range(0, 700) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
